// File: rtl/usb_pkt_rx.sv
// USB packet receiver: parses PID/token/handshake/data packets from the ULPI link byte stream.
// Optional CRC16 payload check enabled by defining USB_PKT_RX_CRC16_CHECK_EN.
module usb_pkt_rx (
  input  logic        CLK_60M,
  input  logic        RST_USB,
  input  logic [7:0]  USB_DATA_OUT,
  input  logic        USB_DATA_OUT_STRB,
  input  logic        USB_DATA_OUT_END,
  input  logic        USB_DATA_OUT_FAIL,
  output logic [3:0]  PID,
  output logic [6:0]  TOKEN_ADDR,
  output logic [3:0]  TOKEN_ENDP,
  output logic        TOKEN_VALID,
  output logic        HS_VALID,
  output logic [7:0]  DATA_BYTE,
  output logic        DATA_STRB,
  output logic        DATA_END,
  output logic [10:0] DATA_LEN,
  output logic        PKT_ERR
);

  typedef enum logic [2:0] {
    ST_IDLE, ST_PID, ST_TOKEN, ST_DATA, ST_HS, ST_DISCARD
  } state_t;

  localparam logic [10:0] MAX_DATA_BYTES = 11'd1026;

  state_t      r_state;
  state_t      w_route;
  state_t      w_state_eff;
  logic [7:0]  r_pid_byte;
  logic [10:0] r_cnt;
  logic [7:0]  r_buf0;
  logic [7:0]  r_buf1;
  logic [7:0]  r_tok_b1;
  logic [2:0]  r_tok_b2;
  logic [4:0]  r_crc5;
  logic        w_pid_ok;
  logic        w_crc5_ok;
  logic        w_crc16_ok;
  logic        w_start;
  logic        w_data_take;

  function automatic logic [4:0] crc5_upd(input logic [4:0] crc, input logic [7:0] d);
    logic [4:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 5'h14;
      else             c = c >> 1;
    end
    return c;
  endfunction

  // ST_PID is a one-cycle decode stage: whatever arrives while in it is handled
  // as if the FSM were already in the state the PID routes to.
  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    w_route  = ST_DISCARD;
    w_pid_ok = (r_pid_byte[7:4] == ~r_pid_byte[3:0]);
    if (w_pid_ok) begin
      case (r_pid_byte[3:0])
        4'h1, 4'h9, 4'h5, 4'hD: w_route = ST_TOKEN;
        4'h3, 4'hB, 4'h7, 4'hF: w_route = ST_DATA;
        4'h2, 4'hA, 4'hE, 4'h6: w_route = ST_HS;
        default:                w_route = ST_DISCARD;
      endcase
    end
    w_state_eff = (r_state == ST_PID) ? w_route : r_state;
  end

  assign w_crc5_ok   = (r_crc5 == 5'h06);
  assign w_start     = (r_state == ST_IDLE) && USB_DATA_OUT_STRB;
  assign w_data_take = (r_state != ST_IDLE) && !USB_DATA_OUT_FAIL && (w_state_eff == ST_DATA) &&
                       USB_DATA_OUT_STRB && (r_cnt != MAX_DATA_BYTES);

`ifdef USB_PKT_RX_CRC16_CHECK_EN
  logic [15:0] r_crc16;

  function automatic logic [15:0] crc16_upd(input logic [15:0] crc, input logic [7:0] d);
    logic [15:0] c;
    c = crc;
    for (int i = 0; i < 8; i++) begin
      if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
      else             c = c >> 1;
    end
    return c;
  endfunction

  always_ff @(posedge CLK_60M) begin
    if (RST_USB)          r_crc16 <= 16'h0000;
    else if (w_start)     r_crc16 <= 16'hFFFF;
    else if (w_data_take) r_crc16 <= crc16_upd(r_crc16, USB_DATA_OUT);
  end

  assign w_crc16_ok = (r_crc16 == 16'hB001);
`else
  assign w_crc16_ok = 1'b1;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK_60M) begin
    if (RST_USB) begin
      r_state     <= ST_IDLE;
      r_pid_byte  <= 8'h00;
      r_cnt       <= 11'd0;
      r_buf0      <= 8'h00;
      r_buf1      <= 8'h00;
      r_tok_b1    <= 8'h00;
      r_tok_b2    <= 3'd0;
      r_crc5      <= 5'h00;
      PID         <= 4'h0;
      TOKEN_ADDR  <= 7'h00;
      TOKEN_ENDP  <= 4'h0;
      TOKEN_VALID <= 1'b0;
      HS_VALID    <= 1'b0;
      DATA_BYTE   <= 8'h00;
      DATA_STRB   <= 1'b0;
      DATA_END    <= 1'b0;
      DATA_LEN    <= 11'd0;
      PKT_ERR     <= 1'b0;
    end else begin
      TOKEN_VALID <= 1'b0;
      HS_VALID    <= 1'b0;
      DATA_STRB   <= 1'b0;
      DATA_END    <= 1'b0;
      PKT_ERR     <= 1'b0;

      if (r_state == ST_IDLE) begin
        if (USB_DATA_OUT_STRB) begin
          r_pid_byte <= USB_DATA_OUT;
          r_cnt      <= 11'd0;
          r_crc5     <= 5'h1F;
          r_state    <= ST_PID;
        end
      end else if (USB_DATA_OUT_FAIL) begin
        PKT_ERR <= 1'b1;
        r_state <= ST_IDLE;
      end else begin
        r_state <= w_state_eff;
        case (w_state_eff)
          ST_TOKEN: begin
            if (USB_DATA_OUT_END) begin
              if ((r_cnt == 11'd2) && w_crc5_ok) begin
                TOKEN_VALID <= 1'b1;
                PID         <= r_pid_byte[3:0];
                TOKEN_ADDR  <= r_tok_b1[6:0];
                TOKEN_ENDP  <= {r_tok_b2, r_tok_b1[7]};
              end else begin
                PKT_ERR <= 1'b1;
              end
              r_state <= ST_IDLE;
            end else if (USB_DATA_OUT_STRB) begin
              if (r_cnt == 11'd2) begin
                r_state <= ST_DISCARD;
              end else begin
                if (r_cnt == 11'd0) r_tok_b1 <= USB_DATA_OUT;
                else                r_tok_b2 <= USB_DATA_OUT[2:0];
                r_crc5 <= crc5_upd(r_crc5, USB_DATA_OUT);
                r_cnt  <= r_cnt + 11'd1;
              end
            end
          end
          ST_HS: begin
            if (USB_DATA_OUT_END) begin
              HS_VALID <= 1'b1;
              PID      <= r_pid_byte[3:0];
              r_state  <= ST_IDLE;
            end else if (USB_DATA_OUT_STRB) begin
              r_state <= ST_DISCARD;
            end
          end
          ST_DATA: begin
            if (USB_DATA_OUT_END) begin
              if ((r_cnt >= 11'd2) && w_crc16_ok) begin
                DATA_END <= 1'b1;
                DATA_LEN <= r_cnt - 11'd2;
                PID      <= r_pid_byte[3:0];
              end else begin
                PKT_ERR <= 1'b1;
              end
              r_state <= ST_IDLE;
            end else if (USB_DATA_OUT_STRB) begin
              if (!w_data_take) begin
                r_state <= ST_DISCARD;
              end else begin
                // The two most recent bytes stay buffered; they become the CRC at END.
                if (r_cnt >= 11'd2) begin
                  DATA_BYTE <= r_buf1;
                  DATA_STRB <= 1'b1;
                end
                r_buf1 <= r_buf0;
                r_buf0 <= USB_DATA_OUT;
                r_cnt  <= r_cnt + 11'd1;
              end
            end
          end
          ST_DISCARD: begin
            if (USB_DATA_OUT_END) begin
              PKT_ERR <= 1'b1;
              r_state <= ST_IDLE;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_pkt_rx.sv
// Randomized scoreboard bench for usb_pkt_rx; the reference model predicts the ordered
// output events of each packet from the packet-level protocol rules.
module tb_usb_pkt_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  din = 8'h00;
  logic        strb = 1'b0;
  logic        pend = 1'b0;
  logic        fail = 1'b0;
  logic [3:0]  pid;
  logic [6:0]  addr;
  logic [3:0]  endp;
  logic        tok_v, hs_v, dstrb, dend, perr;
  logic [7:0]  dbyte;
  logic [10:0] dlen;

  usb_pkt_rx dut (
    .CLK_60M(clk), .RST_USB(rst), .USB_DATA_OUT(din), .USB_DATA_OUT_STRB(strb),
    .USB_DATA_OUT_END(pend), .USB_DATA_OUT_FAIL(fail), .PID(pid), .TOKEN_ADDR(addr),
    .TOKEN_ENDP(endp), .TOKEN_VALID(tok_v), .HS_VALID(hs_v), .DATA_BYTE(dbyte),
    .DATA_STRB(dstrb), .DATA_END(dend), .DATA_LEN(dlen), .PKT_ERR(perr)
  );

  always #5 clk = ~clk;

  typedef enum int {EV_DATA = 0, EV_TOKEN = 1, EV_HS = 2, EV_DEND = 3, EV_ERR = 4} ev_kind_t;
  typedef struct {
    ev_kind_t    kind;
    logic [7:0]  data;
    logic [3:0]  pid;
    logic [6:0]  addr;
    logic [3:0]  endp;
    logic [10:0] len;
  } ev_t;
  typedef logic [7:0] byte_q_t[$];

  localparam int T_END = 0, T_FAIL = 1, T_RESET = 2;

  ev_t        exp_q[$];
  int         n_vec = 0;
  int         n_err = 0;
  logic [3:0] m_pid  = 4'h0;
  logic [6:0] m_addr = 7'h00;
  logic [3:0] m_endp = 4'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] crc5_bits(input logic [10:0] d);
    logic [4:0] c = 5'h1F;
    for (int i = 0; i < 11; i++) c = (c[0] ^ d[i]) ? ((c >> 1) ^ 5'h14) : (c >> 1);
    return c;
  endfunction

  function automatic logic [15:0] crc16_bytes(input byte_q_t b, input int first, input int last);
    logic [15:0] c = 16'hFFFF;
    for (int k = first; k <= last; k++)
      for (int i = 0; i < 8; i++) c = (c[0] ^ b[k][i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
    return c;
  endfunction

  function automatic void push_ev(input ev_kind_t k, input logic [7:0] d, input logic [10:0] len);
    ev_t e;
    e.kind = k; e.data = d; e.len = len;
    e.pid = m_pid; e.addr = m_addr; e.endp = m_endp;
    exp_q.push_back(e);
  endfunction

  // Reference model: the whole packet is known up front, so outcomes follow from its length,
  // PID class and transmitted-vs-recomputed CRC fields.
  task automatic model_pkt(input byte_q_t b, input int term);
    int n, npay, ne;
    logic [3:0]  nib;
    logic [10:0] d11;
    logic [15:0] c16;
    bit ok, is_tok, is_dat, is_hs, good;
    n = b.size();
    if (n == 0) return;
    npay   = n - 1;
    nib    = b[0][3:0];
    ok     = (b[0][7:4] == ~nib);
    is_tok = ok && (nib inside {4'h1, 4'h9, 4'h5, 4'hD});
    is_dat = ok && (nib inside {4'h3, 4'hB, 4'h7, 4'hF});
    is_hs  = ok && (nib inside {4'h2, 4'hA, 4'hE, 4'h6});
    if (is_dat) begin
      ne = ((npay > 1026) ? 1026 : npay) - 2;
      for (int i = 1; i <= ne; i++) push_ev(EV_DATA, b[i], 11'd0);
    end
    if (term == T_RESET) begin
      m_pid = 4'h0; m_addr = 7'h00; m_endp = 4'h0;
      return;
    end
    if (term == T_FAIL) begin
      push_ev(EV_ERR, 8'h00, 11'd0);
      return;
    end
    if (is_tok && npay == 2) begin
      d11 = {b[2][2:0], b[1]};
      if (b[2][7:3] == ~crc5_bits(d11)) begin
        m_pid = nib; m_addr = d11[6:0]; m_endp = d11[10:7];
        push_ev(EV_TOKEN, 8'h00, 11'd0);
      end else push_ev(EV_ERR, 8'h00, 11'd0);
    end else if (is_hs && npay == 0) begin
      m_pid = nib;
      push_ev(EV_HS, 8'h00, 11'd0);
    end else if (is_dat && npay >= 2 && npay <= 1026) begin
      c16  = ~crc16_bytes(b, 1, npay - 2);
      good = ({b[n-1], b[n-2]} == c16);
`ifndef USB_PKT_RX_CRC16_CHECK_EN
      good = 1'b1;
`endif
      if (good) begin
        m_pid = nib;
        push_ev(EV_DEND, 8'h00, 11'(npay - 2));
      end else push_ev(EV_ERR, 8'h00, 11'd0);
    end else begin
      push_ev(EV_ERR, 8'h00, 11'd0);
    end
  endtask

  // Monitor: pops one expected event per observed output pulse.
  always @(negedge clk) begin
    int       np;
    ev_kind_t k;
    ev_t      e;
    np = int'(dstrb) + int'(tok_v) + int'(hs_v) + int'(dend) + int'(perr);
    if (np > 0) begin
      if (np > 1) check("one_pulse_at_a_time", np, 1);
      k = dstrb ? EV_DATA : tok_v ? EV_TOKEN : hs_v ? EV_HS : dend ? EV_DEND : EV_ERR;
      if (exp_q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_pulse: got kind %0d, want no pulse (t=%0t)", int'(k), $time);
      end else begin
        e = exp_q.pop_front();
        check("event_kind", int'(k), int'(e.kind));
        if (e.kind == EV_DATA) check("data_byte", dbyte, e.data);
        else begin
          check("pid", pid, e.pid);
          check("token_addr", addr, e.addr);
          check("token_endp", endp, e.endp);
          if (e.kind == EV_DEND) check("data_len", dlen, e.len);
        end
      end
    end
  end

  task automatic cyc(input logic s, input logic [7:0] d, input logic e, input logic f);
    @(posedge clk); #1;
    strb = s; din = d; pend = e; fail = f;
  endtask

  task automatic send_pkt(input byte_q_t b, input int term, input bit gaps);
    model_pkt(b, term);
    foreach (b[i]) begin
      cyc(1'b1, b[i], 1'b0, 1'b0);
      if (gaps) repeat ($urandom_range(0, 2)) cyc(1'b0, 8'($urandom), 1'b0, 1'b0);
    end
    if (term == T_END)       cyc(1'b0, 8'h00, 1'b1, 1'b0);
    else if (term == T_FAIL) cyc(1'b0, 8'h00, 1'b0, 1'b1);
    else begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0);
      rst = 1'b1;
    end
    cyc(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0);
  endtask

  function automatic byte_q_t mk_token(input logic [3:0] nib, input logic [6:0] a, input logic [3:0] ep);
    byte_q_t q;
    logic [10:0] d11;
    logic [4:0]  c;
    d11 = {ep, a};
    c   = ~crc5_bits(d11);
    q = '{{~nib, nib}, d11[7:0], {c, d11[10:8]}};
    return q;
  endfunction

  function automatic byte_q_t mk_data(input logic [3:0] nib, input int len);
    byte_q_t q;
    logic [15:0] c;
    q.push_back({~nib, nib});
    for (int i = 0; i < len; i++) q.push_back(8'($urandom));
    c = ~crc16_bytes(q, 1, len);
    q.push_back(c[7:0]);
    q.push_back(c[15:8]);
    return q;
  endfunction

  function automatic logic [3:0] pick(input int cls);
    logic [3:0] t[4];
    case (cls)
      0:       t = '{4'h1, 4'h9, 4'h5, 4'hD};
      1:       t = '{4'h3, 4'hB, 4'h7, 4'hF};
      2:       t = '{4'h2, 4'hA, 4'hE, 4'h6};
      default: t = '{4'h0, 4'h4, 4'h8, 4'hC};
    endcase
    return t[$urandom_range(0, 3)];
  endfunction

  initial begin
    byte_q_t q;
    logic [7:0] p;
    int sel, idx;

    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_pid", pid, 0);
    check("rst_addr", addr, 0);
    check("rst_endp", endp, 0);
    check("rst_token_valid", tok_v, 0);
    check("rst_hs_valid", hs_v, 0);
    check("rst_data_byte", dbyte, 0);
    check("rst_data_strb", dstrb, 0);
    check("rst_data_end", dend, 0);
    check("rst_data_len", dlen, 0);
    check("rst_pkt_err", perr, 0);

    // END and FAIL while idle must be ignored.
    cyc(1'b0, 8'h00, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1);
    repeat (3) cyc(1'b0, 8'h00, 1'b0, 1'b0);

    q = '{8'h2D, 8'h00, 8'h10};                  send_pkt(q, T_END, 1'b0);
    q = '{8'hD2};                                send_pkt(q, T_END, 1'b0);
    q = '{8'hD3};                                send_pkt(q, T_END, 1'b0);
    q = '{8'hC3, 8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00, 8'hDD, 8'h94};
    send_pkt(q, T_END, 1'b0);
    q[10] = 8'h95;                               send_pkt(q, T_END, 1'b0);
    q = '{8'hE1, 8'h15, 8'h58};                  send_pkt(q, T_END, 1'b0);
    q = '{8'h2D, 8'h00, 8'h11};                  send_pkt(q, T_END, 1'b0);
    q = '{8'hC3, 8'h11};                         send_pkt(q, T_FAIL, 1'b0);
    q = '{8'h4B, 8'h00, 8'h00};                  send_pkt(q, T_END, 1'b0);
    q = '{8'hC3, 8'h80, 8'h06};                  send_pkt(q, T_RESET, 1'b0);
    q = '{8'hD2};                                send_pkt(q, T_END, 1'b0);

    // Length boundary: 1026 bytes after the PID is the longest legal data packet.
    q = mk_data(4'h3, 1024);                     send_pkt(q, T_END, 1'b0);
    q = mk_data(4'hB, 1025);                     send_pkt(q, T_END, 1'b0);

    for (int it = 0; it < 200; it++) begin
      sel = $urandom_range(0, 11);
      case (sel)
        0: q = mk_token(pick(0), 7'($urandom), 4'($urandom));
        1: begin
          q = mk_token(pick(0), 7'($urandom), 4'($urandom));
          idx = $urandom_range(1, 2);
          q[idx][$urandom_range(0, 7)] ^= 1'b1;
        end
        2: begin
          q = mk_token(pick(0), 7'($urandom), 4'($urandom));
          q.push_back(8'($urandom));
        end
        3: begin p = {~pick(2), 4'h0}; p[3:0] = ~p[7:4]; q = '{p}; end
        4: begin
          p = {4'h0, pick(2)}; p[7:4] = ~p[3:0]; q = '{p};
          repeat ($urandom_range(1, 3)) q.push_back(8'($urandom));
        end
        5: q = mk_data(pick(1), $urandom_range(0, 40));
        6: begin
          q = mk_data(pick(1), $urandom_range(0, 20));
          idx = $urandom_range(1, q.size() - 1);
          q[idx][$urandom_range(0, 7)] ^= 1'b1;
        end
        7: begin
          p = 8'($urandom);
          if (p[7:4] == ~p[3:0]) p[7] = ~p[7];
          q = '{p};
          repeat ($urandom_range(0, 3)) q.push_back(8'($urandom));
        end
        8: begin
          p = {4'h0, pick(3)}; p[7:4] = ~p[3:0]; q = '{p};
          repeat ($urandom_range(0, 3)) q.push_back(8'($urandom));
        end
        9: begin
          p = {4'h0, pick(1)}; p[7:4] = ~p[3:0]; q = '{p};
          repeat ($urandom_range(0, 1)) q.push_back(8'($urandom));
        end
        default: q = mk_data(pick(1), $urandom_range(0, 12));
      endcase
      if (sel == 10)      send_pkt(q, T_FAIL, 1'b1);
      else if (sel == 11) send_pkt(q, ($urandom_range(0, 1) == 0) ? T_RESET : T_FAIL, 1'b1);
      else                send_pkt(q, T_END, 1'b1);
    end

    repeat (20) cyc(1'b0, 8'h00, 1'b0, 1'b0);
    check("expected_events_left", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/usb_pkt_rx.md
USB_PKT_RX -- requirements
Module: usb_pkt_rx

Interface
REQ-001 SHALL: CLK_60M  in  1  ULPI 60 MHz clock; the only clock.
REQ-002 SHALL: RST_USB  in  1  reset, synchronous, active-high.
REQ-003 SHALL: USB_DATA_OUT  in  8  received byte from the ULPI link block.
REQ-004 SHALL: USB_DATA_OUT_STRB  in  1  USB_DATA_OUT valid this cycle.
REQ-005 SHALL: USB_DATA_OUT_END  in  1  one-cycle pulse; packet ended; never coincident with STRB.
REQ-006 SHALL: USB_DATA_OUT_FAIL  in  1  one-cycle pulse; receive aborted by the link.
REQ-007 SHALL: PID  out  4  PID[3:0] of the last accepted packet.
REQ-008 SHALL: TOKEN_ADDR / TOKEN_ENDP  out  7 / 4  token address / endpoint; for SOF: frame number {ENDP,ADDR}.
REQ-009 SHALL: TOKEN_VALID / HS_VALID  out  1 / 1  one-cycle pulse: good token (OUT/IN/SETUP/SOF) / good handshake (ACK/NAK/STALL/NYET).
REQ-010 SHALL: DATA_BYTE / DATA_STRB  out  8 / 1  payload byte with CRC16 stripped / its strobe.
REQ-011 SHALL: DATA_END / DATA_LEN  out  1 / 11  one-cycle pulse: good data packet / payload byte count.
REQ-012 SHALL: PKT_ERR  out  1  one-cycle pulse: packet rejected.

Function
REQ-013 SHALL: FSM states IDLE, PID, TOKEN, DATA, HS, DISCARD; the first strobed byte in IDLE is the PID byte.
REQ-014 SHALL: PID byte check: bits[7:4] == ~bits[3:0]; on failure go to DISCARD.
REQ-015 SHALL: PID routing: token PIDs (x1,x9,x5,xD) -> TOKEN; DATA0/1/2/MDATA (x3,xB,x7,xF) -> DATA; handshakes (x2,xA,xE,x6) -> HS; other PIDs -> DISCARD.
REQ-016 SHALL: TOKEN accepts exactly 2 bytes; ADDR = byte1[6:0], ENDP = {byte2[2:0],byte1[7]}; a third byte -> DISCARD.
REQ-017 SHALL: CRC5 runs LSB-first over the 16 token bits: reflected shift-right register, poly 5'h14, init 5'h1F; valid iff residual == 5'h06.
REQ-018 SHALL: TOKEN_VALID pulses the cycle after END if 2 bytes were received and CRC5 is good; otherwise PKT_ERR pulses.
REQ-019 SHALL: HS: HS_VALID pulses the cycle after END if no byte followed the PID; otherwise PKT_ERR pulses.
REQ-020 SHALL: DATA delays payload through a 2-byte shift buffer; a byte is emitted on DATA_STRB one cycle after the strobe of the byte two positions later, so the 2 trailing CRC bytes are never emitted.
REQ-021 SHALL: DATA byte counter is 11 bits; more than 1026 bytes after the PID -> DISCARD.
REQ-022 SHALL: On END in DATA, fewer than 2 bytes -> PKT_ERR; otherwise DATA_END pulses with DATA_LEN = bytes-2, subject to REQ-030.
REQ-023 SHALL: DISCARD ignores bytes until END or FAIL, then PKT_ERR pulses once and the FSM returns to IDLE.
REQ-024 SHALL: FAIL in any non-IDLE state: PKT_ERR pulses next cycle, FSM -> IDLE, already-emitted payload is not retracted; FAIL and END in IDLE are ignored.
REQ-025 SHALL: PID, TOKEN_ADDR and TOKEN_ENDP update only when their VALID pulse fires and hold otherwise.
REQ-026 SHALL: Exactly one of TOKEN_VALID, HS_VALID, DATA_END or PKT_ERR pulses per terminated packet.

Reset
REQ-027 SHALL: RST_USB sampled high sets the FSM to IDLE and clears all outputs, counters, CRC registers and the shift buffer to 0 on the next edge.
REQ-028 SHALL: RST_USB mid-packet discards the packet with no PKT_ERR; the next strobe after release is treated as a PID.

Configuration
REQ-029 SHALL: Macro USB_PKT_RX_CRC16_CHECK_EN.
REQ-030 SHALL: Defined: CRC16 runs LSB-first over payload+CRC bytes: reflected register, poly 16'hA001, init 16'hFFFF; good iff residual == 16'hB001; a bad residual gives PKT_ERR instead of DATA_END.
REQ-031 SHALL: Undefined: no CRC16 logic; DATA_END is issued regardless of CRC; the CRC bytes are still stripped.

Verification
REQ-032 SHALL: bytes 2D,00,10 then END -> TOKEN_VALID=1, PID=D, ADDR=0, ENDP=0.
REQ-033 SHALL: byte D2 then END -> HS_VALID=1, PID=2; byte D3 then END -> PKT_ERR=1.
REQ-034 SHALL: C3,80,06,00,01,00,00,40,00,DD,94 then END -> 8 DATA_STRB bytes 80..00, DATA_END=1, DATA_LEN=8; with last byte 95 and macro defined -> PKT_ERR.
REQ-035 SHALL: 2D,00,11 then END -> PKT_ERR=1, no TOKEN_VALID, ADDR/ENDP unchanged.
REQ-036 SHALL: C3,11 then FAIL -> PKT_ERR=1, no DATA_STRB; the following 4B,00,00 then END -> DATA_END=1, DATA_LEN=0.
REQ-037 SHALL: RST_USB high after C3,80,06 -> no pulses; the following D2 then END -> HS_VALID=1.
